// File: rtl/pcs_loopback_checker.sv
// pcs_loopback_checker: loopback comparator for the 100GbE PCS datapath.
// Finds the tx->rx pipeline latency automatically, then checks every decoded
// word against the delayed transmitted word and keeps error/word statistics.
// Optional feature macro: PCS_LOOPBACK_CHECKER_CTRL_CMP_EN (compare ctrl too).
module pcs_loopback_checker #(
  parameter int unsigned LEN_DATA    = 64,
  parameter int unsigned LEN_CTRL    = 8,
  parameter int unsigned MAX_LATENCY = 16,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned LEN_ERR_CNT = 32
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic [LEN_DATA-1:0]            i_tx_data,
  input  logic [LEN_CTRL-1:0]            i_tx_ctrl,
  input  logic [LEN_DATA-1:0]            i_rx_data,
  input  logic [LEN_CTRL-1:0]            i_rx_ctrl,
  input  logic                           i_clear,
  output logic                           o_locked,
  output logic [$clog2(MAX_LATENCY):0]   o_latency,
  output logic                           o_mismatch,
  output logic [LEN_ERR_CNT-1:0]         o_err_count,
  output logic [LEN_ERR_CNT-1:0]         o_word_count
);

  localparam int unsigned LEN_PTR = $clog2(MAX_LATENCY);
  localparam int unsigned LEN_LAT = LEN_PTR + 1;
  localparam int unsigned LEN_CNT = $clog2(LOCK_COUNT + 1);
`ifdef PCS_LOOPBACK_CHECKER_CTRL_CMP_EN
  localparam int unsigned LEN_ENTRY = LEN_DATA + LEN_CTRL;
`else
  localparam int unsigned LEN_ENTRY = LEN_DATA;
`endif

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_ENTRY-1:0] hist_mem [MAX_LATENCY];
  logic [LEN_PTR-1:0]   wr_ptr_q, rd_ptr_c;
  logic [LEN_LAT-1:0]   fill_q, latency_d, latency_inc_c;
  logic [LEN_CNT-1:0]   match_cnt_q, match_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [LEN_ENTRY-1:0] tx_entry_c, rx_entry_c, delayed_c;
  logic                 match_c, compare_c, mismatch_d, locked_d;
  logic [LEN_ERR_CNT-1:0] err_cnt_d, word_cnt_d;

  // Select which fields take part in the comparison
`ifdef PCS_LOOPBACK_CHECKER_CTRL_CMP_EN
  assign tx_entry_c = {i_tx_ctrl, i_tx_data};
  assign rx_entry_c = {i_rx_ctrl, i_rx_data};
`else
  assign tx_entry_c = i_tx_data;
  assign rx_entry_c = i_rx_data;
  logic unused_ctrl_c;
  assign unused_ctrl_c = ^{i_tx_ctrl, i_rx_ctrl};
`endif

  // Delayed word lookup; latency MAX_LATENCY aliases the slot about to be written
  assign rd_ptr_c      = wr_ptr_q - o_latency[LEN_PTR-1:0];
  assign delayed_c     = hist_mem[rd_ptr_c];
  assign match_c       = (o_latency <= fill_q) && (rx_entry_c == delayed_c);
  assign latency_inc_c = (o_latency == LEN_LAT'(MAX_LATENCY)) ? LEN_LAT'(1)
                                                               : o_latency + LEN_LAT'(1);

  // History buffer write (contents deliberately not reset; fill_q guards reads)
  always_ff @(posedge i_clock) begin
    if (i_enable) hist_mem[wr_ptr_q] <= tx_entry_c;
  end

  // FSM state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  // Next-state logic: latency search, verification run, and loss-of-lock tracking
  always_comb begin
    state_d     = state_q;
    latency_d   = o_latency;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (i_enable) begin
      case (state_q)
        SEARCH: begin
          if (match_c) begin
            state_d     = VERIFY;
            match_cnt_d = LEN_CNT'(1);
          end else begin
            latency_d = latency_inc_c;
          end
        end
        VERIFY: begin
          if (match_c) begin
            match_cnt_d = match_cnt_q + LEN_CNT'(1);
            if (match_cnt_q == LEN_CNT'(LOCK_COUNT - 1)) state_d = LOCKED;
          end else begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            latency_d   = latency_inc_c;
          end
        end
        LOCKED: begin
          if (match_c) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q == LEN_CNT'(LOCK_COUNT - 1)) begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            bad_cnt_d   = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + LEN_CNT'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output logic: mismatch pulse and saturating statistics with clear override
  always_comb begin
    compare_c  = i_enable && (state_q == LOCKED);
    mismatch_d = compare_c && !match_c;
    locked_d   = (state_d == LOCKED);
    word_cnt_d = o_word_count;
    err_cnt_d  = o_err_count;
    if (i_clear) begin
      word_cnt_d = LEN_ERR_CNT'(compare_c);
      err_cnt_d  = LEN_ERR_CNT'(mismatch_d);
    end else if (compare_c) begin
      if (!(&o_word_count))             word_cnt_d = o_word_count + LEN_ERR_CNT'(1);
      if (mismatch_d && !(&o_err_count)) err_cnt_d = o_err_count + LEN_ERR_CNT'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      match_cnt_q  <= '0;
      bad_cnt_q    <= '0;
      o_latency    <= LEN_LAT'(1);
      o_locked     <= 1'b0;
      o_mismatch   <= 1'b0;
      o_err_count  <= '0;
      o_word_count <= '0;
    end else begin
      if (i_enable) begin
        wr_ptr_q <= wr_ptr_q + LEN_PTR'(1);
        if (fill_q != LEN_LAT'(MAX_LATENCY)) fill_q <= fill_q + LEN_LAT'(1);
      end
      match_cnt_q  <= match_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      o_latency    <= latency_d;
      o_locked     <= locked_d;
      o_mismatch   <= mismatch_d;
      o_err_count  <= err_cnt_d;
      o_word_count <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_pcs_loopback_checker.sv
// Self-checking bench for pcs_loopback_checker: a delay-line channel feeds rx
// from past tx words, and a queue-based reference model predicts all outputs.
module tb_pcs_loopback_checker;

  localparam int unsigned LEN_DATA    = 64;
  localparam int unsigned LEN_CTRL    = 8;
  localparam int unsigned MAX_LATENCY = 16;
  localparam int unsigned LOCK_COUNT  = 8;
  localparam int unsigned LEN_ERR_CNT = 32;
  localparam int unsigned LEN_LAT     = $clog2(MAX_LATENCY) + 1;

  logic                   tb_clock = 1'b0;
  logic                   tb_reset;
  logic                   enable, clear;
  logic [LEN_DATA-1:0]    tx_data, rx_data;
  logic [LEN_CTRL-1:0]    tx_ctrl, rx_ctrl;
  logic                   locked, mismatch;
  logic [LEN_LAT-1:0]     latency;
  logic [LEN_ERR_CNT-1:0] err_count, word_count;

  pcs_loopback_checker #(
    .LEN_DATA(LEN_DATA), .LEN_CTRL(LEN_CTRL), .MAX_LATENCY(MAX_LATENCY),
    .LOCK_COUNT(LOCK_COUNT), .LEN_ERR_CNT(LEN_ERR_CNT)
  ) dut (
    .i_clock(tb_clock), .i_reset(tb_reset), .i_enable(enable),
    .i_tx_data(tx_data), .i_tx_ctrl(tx_ctrl),
    .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl), .i_clear(clear),
    .o_locked(locked), .o_latency(latency), .o_mismatch(mismatch),
    .o_err_count(err_count), .o_word_count(word_count)
  );

  always #5 tb_clock = ~tb_clock;

  int vectors = 0;
  int miscompares = 0;

  // Channel: words accepted by the pipeline; rx is the word from `delay` accepted words ago
  logic [71:0] sent[$];
  int          delay;
  logic [63:0] cnt_word;
  bit          use_cnt;

  // Reference model state
  logic [71:0] m_hist[$];
  int          m_lat;
  bit          m_locked;
  int          m_good, m_bad;
  longint      m_err, m_word;
  bit          m_mis;

  function automatic void model_reset();
    m_hist.delete();
    m_lat = 1; m_locked = 0; m_good = 0; m_bad = 0;
    m_err = 0; m_word = 0; m_mis = 0;
  endfunction

  function automatic bit model_match(input logic [71:0] rx);
    int n;
    logic [71:0] old;
    n = m_hist.size();
    if (m_lat > n) return 1'b0;
    old = m_hist[n - m_lat];
`ifdef PCS_LOOPBACK_CHECKER_CTRL_CMP_EN
    return rx == old;
`else
    return rx[63:0] == old[63:0];
`endif
  endfunction

  function automatic void model_step(input logic [71:0] tx, input logic [71:0] rx,
                                     input bit en, input bit clr);
    bit hit, cmp;
    m_mis = 0;
    cmp = en && m_locked;
    if (en) begin
      hit = model_match(rx);
      if (m_locked) begin
        if (hit) m_bad = 0;
        else begin
          m_mis = 1;
          m_bad++;
          if (m_bad == LOCK_COUNT) begin m_locked = 0; m_good = 0; m_bad = 0; end
        end
      end else if (hit) begin
        m_good++;
        if (m_good == LOCK_COUNT) m_locked = 1;
      end else begin
        m_good = 0;
        m_lat = (m_lat % MAX_LATENCY) + 1;
      end
      m_hist.push_back(tx);
      if (m_hist.size() > 64) void'(m_hist.pop_front());
    end
    if (clr) begin
      m_word = cmp ? 1 : 0;
      m_err  = (cmp && m_mis) ? 1 : 0;
    end else if (cmp) begin
      if (m_word < 64'hFFFF_FFFF) m_word++;
      if (m_mis && m_err < 64'hFFFF_FFFF) m_err++;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("locked",     64'(locked),     64'(m_locked));
    check("latency",    64'(latency),    64'(m_lat));
    check("mismatch",   64'(mismatch),   64'(m_mis));
    check("err_count",  64'(err_count),  64'(m_err));
    check("word_count", 64'(word_count), 64'(m_word));
  endtask

  task automatic step(input bit en, input bit clr, input logic [63:0] dflip, input logic [7:0] cflip);
    logic [71:0] tx, rx;
    if (use_cnt) tx = {8'($urandom), cnt_word};
    else         tx = {8'($urandom), $urandom, $urandom};
    if (sent.size() >= delay) rx = sent[sent.size() - delay];
    else                      rx = {8'($urandom), $urandom, $urandom};
    rx = rx ^ {cflip, dflip};
    enable = en; clear = clr;
    tx_ctrl = tx[71:64]; tx_data = tx[63:0];
    rx_ctrl = rx[71:64]; rx_data = rx[63:0];
    @(posedge tb_clock);
    model_step(tx, rx, en, clr);
    if (en) begin
      sent.push_back(tx);
      if (sent.size() > 64) void'(sent.pop_front());
      if (use_cnt) cnt_word = cnt_word + 64'd1;
    end
    #1;
    check_all();
  endtask

  task automatic run_until_locked(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step(1'b1, 1'b0, 64'd0, 8'd0);
      if (locked === 1'b1) break;
    end
    check(tag, 64'(locked), 64'd1);
  endtask

  task automatic apply_reset();
    tb_reset = 1'b1;
    #2;
    model_reset();
    check_all();
    check("rst_latency_async", 64'(latency), 64'd1);
    check("rst_locked_async",  64'(locked),  64'd0);
    @(posedge tb_clock);
    #1;
    tb_reset = 1'b0;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tb_reset = 1'b1; enable = 1'b0; clear = 1'b0;
    tx_data = '0; tx_ctrl = '0; rx_data = '0; rx_ctrl = '0;
    delay = 5; use_cnt = 1'b1;
    cnt_word = {$urandom, $urandom};
    model_reset();
    @(posedge tb_clock);
    #1;
    check_all();
    check("reset_latency", 64'(latency), 64'd1);
    tb_reset = 1'b0;

    // Lock on an incrementing counter delayed by 5
    run_until_locked(100, "lock5_locked");
    check("lock5_latency", 64'(latency), 64'd5);
    check("lock5_err", 64'(err_count), 64'd0);
    check("lock5_word", 64'(word_count), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 64'd0, 8'd0);
    check("lock5_word3", 64'(word_count), 64'd3);

    // Single corrupted word
    step(1'b1, 1'b0, 64'd1, 8'd0);
    check("single_mismatch", 64'(mismatch), 64'd1);
    check("single_err", 64'(err_count), 64'd1);
    check("single_locked", 64'(locked), 64'd1);
    step(1'b1, 1'b0, 64'd0, 8'd0);
    check("single_pulse_end", 64'(mismatch), 64'd0);

    // Loss of lock after LOCK_COUNT consecutive errors, then relock
    step(1'b1, 1'b1, 64'd0, 8'd0);
    check("clear_word", 64'(word_count), 64'd1);
    check("clear_err", 64'(err_count), 64'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 64'd1, 8'd0);
    check("loss7_locked", 64'(locked), 64'd1);
    step(1'b1, 1'b0, 64'd1, 8'd0);
    check("loss8_locked", 64'(locked), 64'd0);
    check("loss8_err", 64'(err_count), 64'd8);
    run_until_locked(100, "relock_locked");
    check("relock_latency", 64'(latency), 64'd5);
    check("relock_err", 64'(err_count), 64'd8);
    check("relock_word", 64'(word_count), 64'd9);

    // Clear coinciding with a mismatch, then enable low with garbage
    step(1'b1, 1'b1, 64'd1, 8'd0);
    check("clrmis_err", 64'(err_count), 64'd1);
    check("clrmis_word", 64'(word_count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, {$urandom, $urandom} | 64'd1, 8'($urandom));
      check("hold_locked", 64'(locked), 64'd1);
      check("hold_err", 64'(err_count), 64'd1);
      check("hold_word", 64'(word_count), 64'd1);
      check("hold_mismatch", 64'(mismatch), 64'd0);
      check("hold_latency", 64'(latency), 64'd5);
    end
    step(1'b0, 1'b1, 64'd0, 8'd0);
    check("clr_disabled_word", 64'(word_count), 64'd0);

    // Randomized traffic, including a latency change mid-run
    use_cnt = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 120) delay = 1 + int'($urandom_range(MAX_LATENCY - 1));
      step(($urandom % 8) != 0, ($urandom % 32) == 0,
           (($urandom % 16) == 0) ? (64'd1 << ($urandom % 64)) : 64'd0, 8'd0);
    end

    // Reset mid-operation with random inputs on the pins
    tx_data = {$urandom, $urandom}; rx_data = {$urandom, $urandom};
    apply_reset();

    // Largest detectable latency
    delay = MAX_LATENCY;
    run_until_locked(150, "lock16_locked");
    check("lock16_latency", 64'(latency), 64'd16);
    check("lock16_err", 64'(err_count), 64'd0);
    step(1'b1, 1'b0, 64'd0, 8'h01);
`ifdef PCS_LOOPBACK_CHECKER_CTRL_CMP_EN
    check("ctrl_only_err", 64'(err_count), 64'd1);
`else
    check("ctrl_only_err", 64'(err_count), 64'd0);
`endif
    check("ctrl_only_locked", 64'(locked), 64'd1);

    // One beyond the detectable range never locks
    apply_reset();
    delay = MAX_LATENCY + 1;
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 64'd0, 8'd0);
    check("lat17_unlocked", 64'(locked), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
